// File: rtl/instr_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue_pkg
// Description : Shared front-end definitions. Holds the instruction and
//               address types, the default queue depth and the instruction
//               queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_queue_pkg;

    typedef logic [31:0] instr_t;
    typedef logic [31:0] addr_t;

    localparam int IQ_DEPTH = 8;

    // One fetched instruction with its branch-prediction sideband.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        addr_t  pred_npc;
        logic   pred_taken;
    } iq_entry_t;

endpackage : instr_queue_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Head/tail/count bookkeeping for a power-of-two circular
//               buffer. Qualifies push and pop requests against occupancy
//               and flush, and clears everything on reset or flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_req,
    input  logic                     pop_req,
    output logic                     push,
    output logic                     pop,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH)-1:0] tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    // Full blocks enqueue even when a dequeue happens in the same cycle,
    // so the freed slot is never reused combinationally.
    assign full  = (r_count == c_full_cnt);
    assign empty = (r_count == '0);
    assign push  = push_req && !full  && !flush;
    assign pop   = pop_req  && !empty && !flush;

    assign head  = r_head;
    assign tail  = r_tail;
    assign count = r_count;

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (pop) begin
                r_head <= r_head + c_ptr_one;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : Instruction queue between fetch and decode. A flop-based
//               circular FIFO of iq_entry_t with valid/ready handshakes on
//               both sides, a flush for redirects and an occupancy output.
//               The head entry drives decode combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  instr_t                 enq_instr,
    input  addr_t                  enq_pc,
    input  addr_t                  enq_pred_npc,
    input  logic                   enq_pred_taken,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output instr_t                 deq_instr,
    output addr_t                  deq_pc,
    output addr_t                  deq_pred_npc,
    output logic                   deq_pred_taken,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic               w_push;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_head;
    logic [c_ptr_w-1:0] w_tail;
    logic               w_full;
    logic               w_empty;
    iq_entry_t          w_enq_entry;
    iq_entry_t          w_head_entry;

    // Entry storage; deliberately not reset, pointers alone define validity.
    iq_entry_t          r_mem [DEPTH];

    fifo_ptr #(
        .DEPTH    (DEPTH)
    ) u_fifo_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_req (enq_valid),
        .pop_req  (deq_ready),
        .push     (w_push),
        .pop      (w_pop),
        .head     (w_head),
        .tail     (w_tail),
        .count    (count),
        .full     (w_full),
        .empty    (w_empty)
    );

    assign w_enq_entry = '{
        instr:      enq_instr,
        pc:         enq_pc,
        pred_npc:   enq_pred_npc,
        pred_taken: enq_pred_taken
    };

    // Write the incoming entry at tail when the enqueue fires.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_tail] <= w_enq_entry;
        end
    end

    // Head entry is read straight out of the array: no bypass from the
    // enqueue port and no output register toward decode.
    assign w_head_entry   = r_mem[w_head];

    assign enq_ready      = !w_full;
    assign deq_valid      = !w_empty;
    assign deq_instr      = w_head_entry.instr;
    assign deq_pc         = w_head_entry.pc;
    assign deq_pred_npc   = w_head_entry.pred_npc;
    assign deq_pred_taken = w_head_entry.pred_taken;

    // The pop qualifier is consumed inside fifo_ptr; it is exported only
    // for visibility and has no further use here.
    logic w_unused;
    assign w_unused = w_pop;

endmodule : instr_queue
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Self-checking bench for instr_queue. A reference queue of
//               entries is updated from the stimulus each cycle; DUT status
//               and head fields are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    instr_t      enq_instr;
    addr_t       enq_pc;
    addr_t       enq_pred_npc;
    logic        enq_pred_taken;
    logic        deq_valid;
    logic        deq_ready;
    instr_t      deq_instr;
    addr_t       deq_pc;
    addr_t       deq_pred_npc;
    logic        deq_pred_taken;
    logic        flush;
    logic [3:0]  count;

    int          n_checks = 0;
    int          n_errors = 0;
    iq_entry_t   sb[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_instr      (enq_instr),
        .enq_pc         (enq_pc),
        .enq_pred_npc   (enq_pred_npc),
        .enq_pred_taken (enq_pred_taken),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .deq_pred_npc   (deq_pred_npc),
        .deq_pred_taken (deq_pred_taken),
        .flush          (flush),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Present a fresh entry on the enqueue port derived from a pc.
    task automatic set_entry(input addr_t pc);
        enq_pc         = pc;
        enq_instr      = $urandom;
        enq_pred_npc   = pc + 32'd4 + {$urandom_range(0, 15), 2'b00};
        enq_pred_taken = 1'($urandom_range(0, 1));
    endtask

    // Compare DUT against the reference just before the clock edge, then
    // advance the reference by what should fire on that edge.
    task automatic cycle();
        int  sz;
        bit  m_full;
        bit  m_empty;
        @(negedge clk);
        sz      = sb.size();
        m_full  = (sz == DEPTH);
        m_empty = (sz == 0);
        check("count",     32'(count),     32'(sz));
        check("enq_ready", 32'(enq_ready), 32'(!m_full));
        check("deq_valid", 32'(deq_valid), 32'(!m_empty));
        if (!m_empty) begin
            check("deq_pc",         deq_pc,              sb[0].pc);
            check("deq_instr",      deq_instr,           sb[0].instr);
            check("deq_pred_npc",   deq_pred_npc,        sb[0].pred_npc);
            check("deq_pred_taken", 32'(deq_pred_taken), 32'(sb[0].pred_taken));
        end
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (!m_empty && deq_ready) begin
                void'(sb.pop_front());
            end
            if (enq_valid && !m_full) begin
                sb.push_back('{instr: enq_instr, pc: enq_pc,
                               pred_npc: enq_pred_npc, pred_taken: enq_pred_taken});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    // Enqueue n entries with pc starting at base, decode stalled.
    task automatic fill(input int n, inout addr_t pc);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            enq_valid = 1'b1;
            set_entry(pc);
            cycle();
            pc += 32'd4;
        end
        idle_inputs();
    endtask

    initial begin
        addr_t pc;
        rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        set_entry(32'h0);
        @(posedge clk);
        #1;
        cycle();                               // still in reset, queue empty
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();   // idle after reset

        // Fill to full, then a ninth offer that must be refused.
        pc = 32'h1000;
        fill(8, pc);
        check("full_count", 32'(count), 32'd8);
        enq_valid = 1'b1;
        set_entry(32'h1020);
        cycle();
        cycle();
        check("full_hold_count", 32'(count), 32'd8);
        check("full_enq_ready",  32'(enq_ready), 32'd0);

        // Drain in order.
        idle_inputs();
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_pc", deq_pc, 32'h1000 + 32'(i) * 32'd4);
            cycle();
        end
        check("drained_valid", 32'(deq_valid), 32'd0);
        cycle();                               // deq_ready on empty queue

        // Steady state at count 3 with pointers wrapping.
        pc = 32'h2000;
        fill(3, pc);
        for (int i = 0; i < 20; i++) begin
            enq_valid = 1'b1;
            deq_ready = 1'b1;
            set_entry(pc);
            cycle();
            pc += 32'd4;
        end
        check("steady_count", 32'(count), 32'd3);
        idle_inputs();
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Flush with concurrent enqueue and dequeue at count 5.
        idle_inputs();
        pc = 32'h3000;
        fill(5, pc);
        flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
        set_entry(pc);
        cycle();
        idle_inputs();
        cycle();
        check("flush_count", 32'(count), 32'd0);

        // Reset mid-operation with enqueue offered.
        pc = 32'h4000;
        fill(4, pc);
        rst = 1'b1; enq_valid = 1'b1;
        set_entry(pc);
        cycle();
        idle_inputs();
        cycle();
        check("rst_count", 32'(count), 32'd0);

        // Random traffic with occasional flush.
        pc = 32'h8000;
        for (int i = 0; i < 300; i++) begin
            enq_valid = 1'($urandom_range(0, 99) < 60);
            deq_ready = 1'($urandom_range(0, 99) < 45);
            flush     = 1'($urandom_range(0, 99) < 3);
            set_entry(pc);
            cycle();
            pc += 32'd4;
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_instr_queue
`default_nettype wire
